// File: rtl/fetch_pc_predictor_pkg.sv
// Shared Y86 instruction codes and bus widths for the fetch stage.
package fetch_pc_predictor_pkg;

    localparam int unsigned ICODE_BUS = 4;

    typedef logic [ICODE_BUS-1:0] icode_t;

    localparam icode_t NOP  = 4'h1;
    localparam icode_t JXX  = 4'h7;
    localparam icode_t CALL = 4'h8;
    localparam icode_t RET  = 4'h9;

endpackage

// File: rtl/fetch_pc_predictor_ret_addr_stack.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; a pop when empty does nothing.
module ret_addr_stack #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              empty
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]     ptr;
    logic [CW-1:0]     count;

    assign empty = (count == '0);
    assign top   = mem[ptr - PW'(1)];

    // Pointer and occupancy; count saturates so wrapped pushes keep
    // reporting a full stack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (count != CW'(RAS_DEPTH))
                count <= count + CW'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

    // Entry storage; no reset needed since occupancy guards reads.
    always_ff @(posedge clk_i) begin
        if (push)
            mem[ptr] <= din;
    end

endmodule

// File: rtl/fetch_pc_predictor.sv
// Next-PC selection for the Y86 fetch stage: owns predPC, predicts ret
// targets through a return-address stack and checks each prediction in
// order at write-back, redirecting on ret or jump mispredictions.
module fetch_pc_predictor
    import fetch_pc_predictor_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       RAS_DEPTH = 8,
    parameter int unsigned       CHK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 F_stall_i,
    input  logic [ICODE_BUS-1:0] f_icode_i,
    input  logic [ADDR_W-1:0]    f_valC_i,
    input  logic [ADDR_W-1:0]    f_valP_i,
    input  logic [ICODE_BUS-1:0] M_icode_i,
    input  logic                 M_Cnd_i,
    input  logic [ADDR_W-1:0]    M_valA_i,
    input  logic [ICODE_BUS-1:0] W_icode_i,
    input  logic [ADDR_W-1:0]    W_valM_i,
    output logic [ADDR_W-1:0]    f_pc_o,
    output logic                 redirect_o,
    output logic                 ret_stall_o
);

    localparam int unsigned QPW = $clog2(CHK_DEPTH);
    localparam int unsigned QCW = QPW + 1;

    logic [ADDR_W-1:0] pred_pc;
    logic [ADDR_W-1:0] pred_pc_nxt;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] ret_pred;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_push;
    logic              ras_pop;

    logic [ADDR_W-1:0] chk_mem [CHK_DEPTH];
    logic [QPW-1:0]    chk_head;
    logic [QPW-1:0]    chk_tail;
    logic [QCW-1:0]    chk_count;
    logic              chk_empty;
    logic              chk_full;
    logic              chk_enq;
    logic              chk_deq;

    logic w_ret;
    logic ret_bad;
    logic jmp_bad;
    logic redirect;
    logic ret_stall;
    logic accept;

    assign w_ret     = (W_icode_i == RET);
    assign chk_empty = (chk_count == '0);
    assign chk_full  = (chk_count == QCW'(CHK_DEPTH));

    // A ret in W with nothing queued has no prediction to confirm, so it
    // is treated as a misprediction.
    assign ret_bad  = w_ret && (chk_empty || (W_valM_i != chk_mem[chk_head]));
    assign jmp_bad  = (M_icode_i == JXX) && !M_Cnd_i;
    assign redirect = ret_bad || jmp_bad;

    // The ret check wins: a jump still in M is younger, hence wrong-path.
    assign redirect_pc = ret_bad ? W_valM_i : M_valA_i;
    assign f_pc_o      = redirect ? redirect_pc : pred_pc;
    assign redirect_o  = redirect;

    // The W dequeue frees a slot this same cycle, so it lifts the stall.
    assign ret_stall   = (f_icode_i == RET) && chk_full && !w_ret;
    assign ret_stall_o = ret_stall;
    assign accept      = !F_stall_i && !ret_stall;

    assign ras_push = accept && (f_icode_i == CALL);
    assign ras_pop  = accept && (f_icode_i == RET);
    assign ret_pred = ras_empty ? f_valP_i : ras_top;

    assign chk_enq = accept && (f_icode_i == RET);
    assign chk_deq = w_ret && !chk_empty;

    ret_addr_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (f_valP_i),
        .top   (ras_top),
        .empty (ras_empty)
    );

    // Next predicted PC from the accepted instruction, else the redirect
    // target so it is refetched, else hold.
    always_comb begin
        pred_pc_nxt = pred_pc;
        if (accept) begin
            case (f_icode_i)
                JXX, CALL: pred_pc_nxt = f_valC_i;
                RET:       pred_pc_nxt = ret_pred;
                default:   pred_pc_nxt = f_valP_i;
            endcase
        end else if (redirect) begin
            pred_pc_nxt = redirect_pc;
        end
    end

    // predPC register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            pred_pc <= RESET_PC;
        else
            pred_pc <= pred_pc_nxt;
    end

    // Check-queue pointers. A redirect discards everything behind the W
    // dequeue by moving head onto tail; an enqueue in that same cycle lands
    // at the old tail and becomes the only live entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chk_head  <= '0;
            chk_tail  <= '0;
            chk_count <= '0;
        end else if (redirect) begin
            chk_head  <= chk_tail;
            chk_tail  <= chk_tail + QPW'(chk_enq);
            chk_count <= QCW'(chk_enq);
        end else begin
            chk_head  <= chk_head + QPW'(chk_deq);
            chk_tail  <= chk_tail + QPW'(chk_enq);
            chk_count <= chk_count + QCW'(chk_enq) - QCW'(chk_deq);
        end
    end

    // Check-queue storage holds the predicted target of each accepted ret.
    always_ff @(posedge clk_i) begin
        if (chk_enq)
            chk_mem[chk_tail] <= ret_pred;
    end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed bench for fetch_pc_predictor: single-cycle vector table from
// reset plus multi-cycle sequences for RAS, check queue and reset.
module tb_fetch_pc_predictor;
    import fetch_pc_predictor_pkg::*;

    localparam logic [63:0] RPC = 64'h10;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        F_stall_i;
    logic [3:0]  f_icode_i;
    logic [63:0] f_valC_i;
    logic [63:0] f_valP_i;
    logic [3:0]  M_icode_i;
    logic        M_Cnd_i;
    logic [63:0] M_valA_i;
    logic [3:0]  W_icode_i;
    logic [63:0] W_valM_i;
    logic [63:0] f_pc_o;
    logic        redirect_o;
    logic        ret_stall_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    fetch_pc_predictor #(
        .ADDR_W    (64),
        .RAS_DEPTH (8),
        .CHK_DEPTH (4),
        .RESET_PC  (RPC)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .F_stall_i   (F_stall_i),
        .f_icode_i   (f_icode_i),
        .f_valC_i    (f_valC_i),
        .f_valP_i    (f_valP_i),
        .M_icode_i   (M_icode_i),
        .M_Cnd_i     (M_Cnd_i),
        .M_valA_i    (M_valA_i),
        .W_icode_i   (W_icode_i),
        .W_valM_i    (W_valM_i),
        .f_pc_o      (f_pc_o),
        .redirect_o  (redirect_o),
        .ret_stall_o (ret_stall_o)
    );

    typedef struct {
        logic [3:0]  fi;
        logic [63:0] fc;
        logic [63:0] fp;
        logic [3:0]  mi;
        logic        mc;
        logic [63:0] ma;
        logic [3:0]  wi;
        logic [63:0] wm;
        logic        st;
        logic [63:0] e_pc;
        logic        e_red;
        logic        e_rs;
        logic [63:0] e_next;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] fi, input logic [63:0] fc, input logic [63:0] fp,
                          input logic [3:0] mi, input logic mc, input logic [63:0] ma,
                          input logic [3:0] wi, input logic [63:0] wm, input logic st);
        f_icode_i = fi; f_valC_i = fc; f_valP_i = fp;
        M_icode_i = mi; M_Cnd_i = mc; M_valA_i = ma;
        W_icode_i = wi; W_valM_i = wm; F_stall_i = st;
    endtask

    task automatic idle();
        set_in(NOP, '0, '0, NOP, 1'b0, '0, NOP, '0, 1'b1);
    endtask

    // Advance one clock, then park inputs so f_pc_o shows predPC.
    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        #3;
        rst_i = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic fetch(input logic [3:0] fi, input logic [63:0] fc, input logic [63:0] fp);
        set_in(fi, fc, fp, NOP, 1'b0, '0, NOP, '0, 1'b0);
        #1;
        cyc();
    endtask

    logic [63:0] r [9];
    logic [63:0] pc;

    initial begin
        rst_i = 1'b0;
        idle();

        vecs[0]  = '{NOP,  64'h0,   64'h11, NOP, 1'b0, 64'h0,  NOP, 64'h0,  1'b0, 64'h10, 1'b0, 1'b0, 64'h11};
        vecs[1]  = '{JXX,  64'h200, 64'h19, NOP, 1'b0, 64'h0,  NOP, 64'h0,  1'b0, 64'h10, 1'b0, 1'b0, 64'h200};
        vecs[2]  = '{CALL, 64'h300, 64'h19, NOP, 1'b0, 64'h0,  NOP, 64'h0,  1'b0, 64'h10, 1'b0, 1'b0, 64'h300};
        vecs[3]  = '{RET,  64'h0,   64'h11, NOP, 1'b0, 64'h0,  NOP, 64'h0,  1'b0, 64'h10, 1'b0, 1'b0, 64'h11};
        vecs[4]  = '{NOP,  64'h0,   64'h11, NOP, 1'b0, 64'h0,  NOP, 64'h0,  1'b1, 64'h10, 1'b0, 1'b0, 64'h10};
        vecs[5]  = '{NOP,  64'h0,   64'h51, JXX, 1'b0, 64'h50, NOP, 64'h0,  1'b0, 64'h50, 1'b1, 1'b0, 64'h51};
        vecs[6]  = '{NOP,  64'h0,   64'h11, JXX, 1'b1, 64'h50, NOP, 64'h0,  1'b0, 64'h10, 1'b0, 1'b0, 64'h11};
        vecs[7]  = '{NOP,  64'h0,   64'h81, NOP, 1'b0, 64'h0,  RET, 64'h80, 1'b0, 64'h80, 1'b1, 1'b0, 64'h81};
        vecs[8]  = '{NOP,  64'h0,   64'h81, JXX, 1'b0, 64'h50, RET, 64'h80, 1'b1, 64'h80, 1'b1, 1'b0, 64'h80};
        vecs[9]  = '{NOP,  64'h0,   64'h51, JXX, 1'b0, 64'h50, NOP, 64'h0,  1'b1, 64'h50, 1'b1, 1'b0, 64'h50};
        vecs[10] = '{JXX,  64'h200, 64'h19, NOP, 1'b0, 64'h0,  NOP, 64'h0,  1'b1, 64'h10, 1'b0, 1'b0, 64'h10};

        // Single-cycle vectors, each from a fresh reset.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            set_in(vecs[i].fi, vecs[i].fc, vecs[i].fp, vecs[i].mi, vecs[i].mc,
                   vecs[i].ma, vecs[i].wi, vecs[i].wm, vecs[i].st);
            #1;
            check($sformatf("v%0d_pc", i), f_pc_o, vecs[i].e_pc);
            check($sformatf("v%0d_redirect", i), 64'(redirect_o), 64'(vecs[i].e_red));
            check($sformatf("v%0d_ret_stall", i), 64'(ret_stall_o), 64'(vecs[i].e_rs));
            cyc();
            check($sformatf("v%0d_next_pc", i), f_pc_o, vecs[i].e_next);
        end

        // Reset mid-run with predPC=0x40 and RAS/queue populated.
        do_reset();
        fetch(CALL, 64'h20, 64'h19);
        fetch(CALL, 64'h30, 64'h29);
        fetch(RET,  64'h0,  64'h31);
        check("rst_pre_ret_pred", f_pc_o, 64'h29);
        fetch(JXX,  64'h40, 64'h32);
        check("rst_pre_pc", f_pc_o, 64'h40);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_async_pc", f_pc_o, RPC);
        check("rst_redirect", 64'(redirect_o), 64'h0);
        check("rst_ret_stall", 64'(ret_stall_o), 64'h0);
        #2;
        rst_i = 1'b0;
        @(posedge clk);
        #2;
        check("rst_after_pc", f_pc_o, RPC);
        set_in(NOP, '0, '0, NOP, 1'b0, '0, RET, 64'h29, 1'b1);
        #1;
        check("rst_queue_empty", 64'(redirect_o), 64'h1);
        cyc();
        fetch(RET, 64'h0, 64'h77);
        check("rst_ras_empty", f_pc_o, 64'h77);

        // CALL at 0x100, RET predicted from RAS, confirmed at W.
        do_reset();
        fetch(JXX, 64'h100, 64'h19);
        fetch(CALL, 64'h200, 64'h109);
        check("call_target", f_pc_o, 64'h200);
        set_in(RET, '0, 64'h201, NOP, 1'b0, '0, NOP, '0, 1'b0);
        #1;
        check("ret_no_stall", 64'(ret_stall_o), 64'h0);
        cyc();
        check("ret_pred_pc", f_pc_o, 64'h109);
        set_in(NOP, '0, '0, NOP, 1'b0, '0, RET, 64'h109, 1'b1);
        #1;
        check("ret_ok_redirect", 64'(redirect_o), 64'h0);
        check("ret_ok_pc", f_pc_o, 64'h109);
        cyc();
        set_in(NOP, '0, '0, NOP, 1'b0, '0, RET, 64'h109, 1'b1);
        #1;
        check("ret_dequeued", 64'(redirect_o), 64'h1);
        cyc();

        // Ret mispredicted at W clears the remaining queued prediction.
        do_reset();
        fetch(JXX, 64'h100, 64'h19);
        fetch(CALL, 64'h200, 64'h109);
        fetch(RET, 64'h0, 64'h201);
        fetch(CALL, 64'h500, 64'h112);
        fetch(RET, 64'h0, 64'h501);
        check("bad_setup_pc", f_pc_o, 64'h112);
        set_in(NOP, '0, '0, NOP, 1'b0, '0, RET, 64'h300, 1'b1);
        #1;
        check("bad_ret_pc", f_pc_o, 64'h300);
        check("bad_ret_redirect", 64'(redirect_o), 64'h1);
        cyc();
        check("bad_ret_refetch", f_pc_o, 64'h300);
        set_in(NOP, '0, '0, NOP, 1'b0, '0, RET, 64'h112, 1'b1);
        #1;
        check("bad_ret_cleared", 64'(redirect_o), 64'h1);
        cyc();

        // Redirect clears queue but keeps the same-cycle enqueue.
        do_reset();
        fetch(RET, 64'h0, 64'h11);
        fetch(RET, 64'h0, 64'h12);
        set_in(RET, '0, 64'h61, JXX, 1'b0, 64'h50 + 64'h10, NOP, '0, 1'b0);
        #1;
        check("keep_redirect_pc", f_pc_o, 64'h60);
        cyc();
        check("keep_pred_pc", f_pc_o, 64'h61);
        set_in(NOP, '0, '0, NOP, 1'b0, '0, RET, 64'h61, 1'b1);
        #1;
        check("keep_enq_match", 64'(redirect_o), 64'h0);
        cyc();
        set_in(NOP, '0, '0, NOP, 1'b0, '0, RET, 64'h12, 1'b1);
        #1;
        check("keep_old_cleared", 64'(redirect_o), 64'h1);
        cyc();

        // CHK_DEPTH+1 rets: last one stalls, then a W ret frees a slot.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(RET, '0, RPC + 64'(i) + 64'h1, NOP, 1'b0, '0, NOP, '0, 1'b0);
            #1;
            check($sformatf("fill%0d_no_stall", i), 64'(ret_stall_o), 64'h0);
            cyc();
        end
        check("fill_pc", f_pc_o, 64'h14);
        set_in(RET, '0, 64'h15, NOP, 1'b0, '0, NOP, '0, 1'b0);
        #1;
        check("full_ret_stall", 64'(ret_stall_o), 64'h1);
        cyc();
        check("full_pc_held", f_pc_o, 64'h14);
        set_in(RET, '0, 64'h15, NOP, 1'b0, '0, RET, 64'h11, 1'b0);
        #1;
        check("full_w_pop_stall", 64'(ret_stall_o), 64'h0);
        check("full_w_pop_redirect", 64'(redirect_o), 64'h0);
        cyc();
        check("full_w_pop_pc", f_pc_o, 64'h15);
        for (int i = 0; i < 4; i++) begin
            set_in(NOP, '0, '0, NOP, 1'b0, '0, RET, 64'h12 + 64'(i), 1'b1);
            #1;
            check($sformatf("drain%0d_redirect", i), 64'(redirect_o), 64'h0);
            cyc();
        end

        // RAS_DEPTH+1 nested calls then matching rets.
        do_reset();
        pc = RPC;
        for (int k = 0; k < 9; k++) begin
            r[k] = pc + 64'h9;
            fetch(CALL, 64'h1000 * 64'(k + 1), r[k]);
            pc = 64'h1000 * 64'(k + 1);
            check($sformatf("nest_call%0d_pc", k), f_pc_o, pc);
        end
        for (int j = 0; j < 9; j++) begin
            if (j == 0)
                set_in(RET, '0, pc + 64'h1, NOP, 1'b0, '0, NOP, '0, 1'b0);
            else
                set_in(RET, '0, pc + 64'h1, NOP, 1'b0, '0, RET, r[9-j], 1'b0);
            #1;
            check($sformatf("nest_ret%0d_redirect", j), 64'(redirect_o), 64'h0);
            cyc();
            if (j < 8)
                check($sformatf("nest_ret%0d_pred", j), f_pc_o, r[8-j]);
            else
                check("nest_ret8_fallthru", f_pc_o, r[1] + 64'h1);
            pc = f_pc_o;
        end
        set_in(NOP, '0, '0, NOP, 1'b0, '0, RET, r[0], 1'b1);
        #1;
        check("nest_fix_redirect", 64'(redirect_o), 64'h1);
        check("nest_fix_pc", f_pc_o, r[0]);
        cyc();
        check("nest_fix_refetch", f_pc_o, r[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_pc_predictor.md
Name: fetch_pc_predictor

Overview:
- Parametrised next-generation PC selection for the Y86 pipelined fetch stage.
- Owns the F_predPC register internally and predicts ret targets with a return-address stack (RAS), so a ret no longer forces fetch to wait for write-back.
- Verifies each ret prediction in order at write-back, and redirects on either a jump misprediction or a ret misprediction.
- Sits between the F pipeline register and instruction memory; drives f_pc_o each cycle.

Parameters:
- ADDR_W, 64, address/PC width in bits.
- RAS_DEPTH, 8, return-address stack entries (power of two, >=2).
- CHK_DEPTH, 4, outstanding ret-prediction check queue entries (power of two, >=2).
- RESET_PC, 0, PC loaded into the predPC register at reset.

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, reset; asynchronous, active-high.
- F_stall_i, input, 1, fetch stall: hold fetch state.
- f_icode_i, input, 4, icode of the instruction fetched at f_pc_o this cycle.
- f_valC_i, input, ADDR_W, constant word of the fetched instruction.
- f_valP_i, input, ADDR_W, fall-through PC of the fetched instruction.
- M_icode_i, input, 4, icode in the memory stage.
- M_Cnd_i, input, 1, condition result in the memory stage.
- M_valA_i, input, ADDR_W, fall-through PC of the jump in the memory stage.
- W_icode_i, input, 4, icode in write-back.
- W_valM_i, input, ADDR_W, actual return address of the ret in write-back.
- f_pc_o, output, ADDR_W, PC to fetch this cycle.
- redirect_o, output, 1, misprediction redirect this cycle; consumed by pipeline control to bubble D/E.
- ret_stall_o, output, 1, fetched RET cannot be accepted because the check queue is full.

Behaviour:
- Reset (async, immediate): predPC=RESET_PC, RAS empty (ptr=0, count=0), check queue empty. With no redirect asserted, the outputs are then f_pc_o=RESET_PC, redirect_o=0, ret_stall_o=0.
- ret_bad: W_icode_i==RET and (W_valM_i != queue head, or queue empty).
- jmp_bad: M_icode_i==JXX and !M_Cnd_i.
- f_pc_o selection (combinational), in priority order:
  - ret_bad: W_valM_i.
  - else jmp_bad: M_valA_i.
  - else: predPC.
- ret_bad outranks jmp_bad because the M-stage jump is then on the wrong path.
- redirect_o = ret_bad | jmp_bad.
- "accept" = !F_stall_i && !ret_stall_o.
- ret_stall_o = (f_icode_i==RET) && queue full && !(W pops this cycle). The W pop frees a slot the same cycle.
- predPC next value:
  - If accept, from the fetched instruction:
    - JXX or CALL: f_valC_i.
    - RET: RAS top if RAS non-empty, else f_valP_i.
    - otherwise: f_valP_i.
  - If not accept and redirect: redirect target, so it is refetched.
  - Else: hold.
- RAS, updated only on accept:
  - CALL pushes f_valP_i. When full, the push overwrites the oldest entry (circular pointer, count saturates at RAS_DEPTH).
  - RET pops. Pop when empty is a no-op.
  - RAS is never repaired on wrong-path activity. This costs performance only; correctness comes from the W check.
- Check queue, in-order FIFO:
  - Accepted RET enqueues its predicted target (RAS top or f_valP_i).
  - W_icode_i==RET dequeues the head every time, match or not.
- On redirect, all queue entries after the W dequeue are cleared the same cycle. An enqueue from the redirected fetch in that cycle is kept; it is the only surviving entry.
- Latency: f_pc_o is combinational; all state updates take effect at the next clock edge.
- Bubble/stall inputs never suppress the W check or the redirect.

Decomposition:
- Shared define file holds the icode constants (JXX, CALL, RET, NOP) and the ICODE_BUS width; the block uses those exclusively.
- One natural sub-module: ret_addr_stack, parameters (ADDR_W, RAS_DEPTH):
  - inputs: push, pop, din;
  - outputs: top, empty.
- The check queue stays inline, about 40 lines.

Test Plan:
- Reset mid-run with predPC=0x40: assert rst_i asynchronously -> f_pc_o=RESET_PC immediately; RAS and queue empty after release.
- CALL at 0x100 (valC=0x200, valP=0x109), later RET fetched -> next f_pc_o=0x109 with no stall cycles. W ret with W_valM=0x109 -> redirect_o stays 0.
- RAS corrupted so RET predicts 0x109 while W_valM=0x300 -> in the W cycle, f_pc_o=0x300 and redirect_o=1; the queue is cleared the next cycle.
- JXX not taken in M (M_valA=0x50) with W ret mispredicted (W_valM=0x80) in the same cycle -> f_pc_o=0x80; without the ret mispredict -> f_pc_o=0x50.
- CHK_DEPTH+1 RETs fetched with no W retire -> ret_stall_o=1 on the last RET and predPC held. The same scenario with a W ret in that cycle -> ret_stall_o=0.
- RAS_DEPTH+1 nested CALLs then matching RETs -> the first RAS_DEPTH predictions are correct; the last RET predicts wrongly and is corrected at W via redirect.
